// File: rtl/aes_pkg.sv
// Shared AES constants and types: round constants, word/key types, and the
// key-expansion state encoding.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  localparam logic [7:0] RCON [0:NUM_ROUNDS-1] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef logic [31:0]  word_t;
  typedef logic [127:0] key_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_FINISH = 2'd2
  } kexp_state_t;

  // Indices outside 0..NUM_ROUNDS-1 return zero rather than an X.
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < NUM_ROUNDS; i++) begin
      if (r == 4'(i)) v = RCON[i];
    end
    return v;
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_expansion_if.sv
// Request/response and round-key memory write bus of the key expansion block.
// KEY_EXP_LAST_KEY_EN adds the retained copy of round key 10.
interface aes_key_expansion_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 4
);
  logic                  start;
  logic [DATA_WIDTH-1:0] key_in;
  logic                  busy;
  logic                  done;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
`ifdef KEY_EXP_LAST_KEY_EN
  logic [DATA_WIDTH-1:0] last_key;
`endif

  modport master (
    output start, key_in,
    input  busy, done, mem_we, mem_addr, mem_din
`ifdef KEY_EXP_LAST_KEY_EN
    , input last_key
`endif
  );

  modport slave (
    input  start, key_in,
    output busy, done, mem_we, mem_addr, mem_din
`ifdef KEY_EXP_LAST_KEY_EN
    , output last_key
`endif
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES S-box (forward). Shared between key expansion SubWord and
// the SubBytes stage.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Row-major table, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] base;

  always_comb begin
    base = {~din, 3'b000};
    dout = SBOX_FLAT[base +: 8];
  end

endmodule

// File: rtl/aes_key_expansion.sv
// AES-128 key schedule: writes round keys 0..10 to the round-key memory, one
// per cycle. KEY_EXP_LAST_KEY_EN keeps round key 10 on bus.last_key.
//   state     | meaning
//   ST_IDLE   | waiting for start; key latched on the accepting edge
//   ST_EXPAND | writing round keys 0..9, computing the next one each cycle
//   ST_FINISH | writing round key 10; done pulses in the following cycle
module aes_key_expansion
  import aes_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 11,
  parameter int ADDR_WIDTH = 4
) (
  input logic                clk,
  input logic                rst,
  aes_key_expansion_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ROUND = ADDR_WIDTH'(DEPTH - 1);

  kexp_state_t           state_q, state_n;
  logic [ADDR_WIDTH-1:0] round_q, round_n;
  logic [DATA_WIDTH-1:0] cur_key_q, cur_key_n;
  logic                  busy_q, busy_n;
  logic                  we_q, we_n;
  logic                  done_q, done_n;

  word_t rot_w3;
  word_t sub_w3;
  word_t t_word;
  key_t  next_key;

  assign rot_w3 = rot_word(cur_key_q[31:0]);

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .din  (rot_w3[8*b +: 8]),
      .dout (sub_w3[8*b +: 8])
    );
  end

  // Each new word folds in its left neighbour from the same round.
  always_comb begin
    t_word = sub_w3 ^ {rcon_of(round_q), 24'h000000};
    next_key[127:96] = cur_key_q[127:96] ^ t_word;
    next_key[95:64]  = cur_key_q[95:64]  ^ next_key[127:96];
    next_key[63:32]  = cur_key_q[63:32]  ^ next_key[95:64];
    next_key[31:0]   = cur_key_q[31:0]   ^ next_key[63:32];
  end

  always_comb begin
    state_n   = state_q;
    round_n   = round_q;
    cur_key_n = cur_key_q;
    busy_n    = busy_q;
    we_n      = we_q;
    done_n    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_n   = ST_EXPAND;
          round_n   = '0;
          cur_key_n = bus.key_in;
          busy_n    = 1'b1;
          we_n      = 1'b1;
        end
      end
      ST_EXPAND: begin
        cur_key_n = next_key;
        round_n   = round_q + 1'b1;
        if (round_q == LAST_ROUND - 1'b1) state_n = ST_FINISH;
      end
      ST_FINISH: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
        we_n    = 1'b0;
        done_n  = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      round_q   <= '0;
      cur_key_q <= '0;
      busy_q    <= 1'b0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      round_q   <= round_n;
      cur_key_q <= cur_key_n;
      busy_q    <= busy_n;
      we_q      <= we_n;
      done_q    <= done_n;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.mem_we   = we_q;
  assign bus.mem_addr = round_q;
  assign bus.mem_din  = cur_key_q;

`ifdef KEY_EXP_LAST_KEY_EN
  logic [DATA_WIDTH-1:0] last_key_q;

  // Captured on the same edge the memory takes round key 10.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_key_q <= '0;
    end else if (state_q == ST_FINISH) begin
      last_key_q <= cur_key_q;
    end
  end

  assign bus.last_key = last_key_q;
`else
  // No retained copy of round key 10 in this build.
`endif

endmodule

// File: tb/tb_aes_key_expansion.sv
// Directed bench for aes_key_expansion: FIPS-197 and all-zero key schedules,
// held start, back-to-back runs and reset abort.
module tb_aes_key_expansion;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  aes_key_expansion_if #(.DATA_WIDTH(128), .ADDR_WIDTH(4)) bus ();

  aes_key_expansion #(
    .DATA_WIDTH (128),
    .DEPTH      (11),
    .ADDR_WIDTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [127:0] K_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_ZERO = 128'h0;
  localparam logic [127:0] A1_R5  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
  localparam logic [127:0] A1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_R1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   addr;
    logic [127:0] exp;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  int tests = 0;
  int fails = 0;

  // Round-key memory model plus bus observers.
  logic [127:0] mem [0:15];
  int           wr_cnt   = 0;
  int           done_cnt = 0;
  int           bad_addr = 0;
  int           seq_err  = 0;
  logic [3:0]   exp_addr = 4'd0;

  always @(negedge clk) begin
    if (rst) begin
      exp_addr = 4'd0;
    end else begin
      if (bus.mem_we) begin
        if (bus.mem_addr > 4'd10) bad_addr++;
        if (bus.mem_addr != exp_addr) seq_err++;
        mem[bus.mem_addr] = bus.mem_din;
        wr_cnt++;
        exp_addr = (bus.mem_addr == 4'd10) ? 4'd0 : bus.mem_addr + 4'd1;
      end
      if (bus.done) done_cnt++;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 'x;
  endtask

  // One start pulse; key_in is scrambled right after the accepting edge.
  // bp/dp bit c holds busy/done in cycle T0+1+c.
  task automatic run_key(input logic [127:0] k, output logic [12:0] bp, output logic [12:0] dp);
    clear_mem();
    @(negedge clk);
    bus.start  = 1'b1;
    bus.key_in = k;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.key_in = ~k;
    for (int c = 0; c < 13; c++) begin
      bp[c] = bus.busy;
      dp[c] = bus.done;
      @(negedge clk);
    end
  endtask

  logic [12:0] bp, dp;
  int          wr0, done0;

  initial begin
    vecs[0]  = '{K_A1,   4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[1]  = '{K_A1,   4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2]  = '{K_A1,   4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    vecs[3]  = '{K_A1,   4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    vecs[4]  = '{K_A1,   4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    vecs[5]  = '{K_A1,   4'd5,  A1_R5};
    vecs[6]  = '{K_A1,   4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    vecs[7]  = '{K_A1,   4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    vecs[8]  = '{K_A1,   4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    vecs[9]  = '{K_A1,   4'd9,  128'hac7766f319fadc2128d12941575c006e};
    vecs[10] = '{K_A1,   4'd10, A1_R10};
    vecs[11] = '{K_ZERO, 4'd0,  K_ZERO};
    vecs[12] = '{K_ZERO, 4'd1,  Z_R1};
    vecs[13] = '{K_ZERO, 4'd10, Z_R10};

    bus.start  = 1'b0;
    bus.key_in = '0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy",     128'(bus.busy),     128'd0);
    check("rst_done",     128'(bus.done),     128'd0);
    check("rst_mem_we",   128'(bus.mem_we),   128'd0);
    check("rst_mem_addr", 128'(bus.mem_addr), 128'd0);
    check("rst_mem_din",  bus.mem_din,        128'd0);
`ifdef KEY_EXP_LAST_KEY_EN
    check("rst_last_key", bus.last_key,       128'd0);
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      if (i == 0 || vecs[i].key !== vecs[i-1].key) begin
        run_key(vecs[i].key, bp, dp);
        check("busy_window", 128'(bp), 128'h07ff);
        check("done_pulse",  128'(dp), 128'h0800);
      end
      check($sformatf("key%0h_addr%0d", vecs[i].key[7:0], vecs[i].addr), mem[vecs[i].addr], vecs[i].exp);
    end
`ifdef KEY_EXP_LAST_KEY_EN
    check("last_key_zero", bus.last_key, Z_R10);
`endif

    // start held through the run, key_in changed, second start in the done cycle
    wr0   = wr_cnt;
    done0 = done_cnt;
    clear_mem();
    @(negedge clk);
    bus.start  = 1'b1;
    bus.key_in = K_A1;
    @(negedge clk);
    bus.key_in = K_ZERO;
    repeat (11) @(negedge clk);
    check("hold_done_t12",   128'(bus.done), 128'd1);
    check("hold_single_run", 128'(wr_cnt - wr0), 128'd11);
    check("hold_addr5",      mem[5],  A1_R5);
    check("hold_addr10",     mem[10], A1_R10);
`ifdef KEY_EXP_LAST_KEY_EN
    check("last_key_a1", bus.last_key, A1_R10);
`endif
    @(negedge clk);
    check("b2b_busy",  128'(bus.busy),     128'd1);
    check("b2b_addr0", 128'(bus.mem_addr), 128'd0);
    check("b2b_din0",  bus.mem_din,        K_ZERO);
    bus.start  = 1'b0;
    bus.key_in = K_A1;
    repeat (11) @(negedge clk);
    check("b2b_done",   128'(bus.done), 128'd1);
    check("b2b_addr1",  mem[1],  Z_R1);
    check("b2b_addr10", mem[10], Z_R10);
`ifdef KEY_EXP_LAST_KEY_EN
    check("last_key_b2b", bus.last_key, Z_R10);
`endif
    @(negedge clk);
    check("b2b_done_count",  128'(done_cnt - done0), 128'd2);
    check("b2b_write_count", 128'(wr_cnt - wr0),     128'd22);
    check("b2b_no_third",    128'(bus.busy),         128'd0);

    // reset in cycle T0+5 aborts the run
    done0 = done_cnt;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.key_in = K_A1;
    @(negedge clk);
    bus.start  = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy",     128'(bus.busy),     128'd0);
    check("abort_mem_we",   128'(bus.mem_we),   128'd0);
    check("abort_mem_addr", 128'(bus.mem_addr), 128'd0);
    check("abort_mem_din",  bus.mem_din,        128'd0);
`ifdef KEY_EXP_LAST_KEY_EN
    check("abort_last_key", bus.last_key,       128'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (14) @(negedge clk);
    check("abort_no_done", 128'(done_cnt - done0), 128'd0);

    run_key(K_A1, bp, dp);
    check("rerun_busy_window", 128'(bp), 128'h07ff);
    check("rerun_done_pulse",  128'(dp), 128'h0800);
    check("rerun_addr0",  mem[0],  K_A1);
    check("rerun_addr7",  mem[7],  vecs[7].exp);
    check("rerun_addr10", mem[10], A1_R10);
`ifdef KEY_EXP_LAST_KEY_EN
    repeat (5) @(negedge clk);
    check("last_key_held", bus.last_key, A1_R10);
`endif

    check("illegal_addr_writes", 128'(bad_addr), 128'd0);
    check("addr_sequence",       128'(seq_err),  128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
